// File: rtl/memory_reader_pkg.sv
// Shared definitions for the pulse-recorder RAM masters: default geometry,
// read FSM state encoding and the circular-address helper.
package memory_reader_pkg;
  localparam int RAM_SIZE_DEF = 256;
  localparam int ADDR_BUS_DEF = 8;
  localparam int COORD_W      = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_e;

  // (a + b) mod size, valid for a < size and b <= size
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned size);
    int unsigned s;
    s = a + b;
    if (s >= size) s = s - size;
    return s;
  endfunction
endpackage

// File: rtl/memory_reader_fifo.sv
// Synchronous skid FIFO for the read-back stream; count feeds the read credit check.
module mem_reader_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
endmodule

// File: rtl/memory_reader.sv
// Reads a recorded window out of the circular RAM oldest-first onto a valid/ready stream.
// Optional header beat carrying pulse_coord: define MEM_READER_HEADER_EN.
module memory_reader
  import memory_reader_pkg::*;
#(
  parameter int RAM_SIZE   = RAM_SIZE_DEF,
  parameter int ADDR_BUS   = ADDR_BUS_DEF,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                ref_clk,
  input  logic                reset,
  input  logic                rd_start,
  input  logic [ADDR_BUS-1:0] rd_end_ptr,
  input  logic [ADDR_BUS:0]   rd_len,
  input  logic [COORD_W-1:0]  pulse_coord,
  input  logic                rd_abort,
  output logic                av_cs,
  output logic                av_read,
  output logic [ADDR_BUS-1:0] av_addr,
  input  logic [DATA_W-1:0]   av_readdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int FW = DATA_W + 1;
  localparam logic [CW+1:0]   CREDITS = (CW+2)'(FIFO_DEPTH);
  localparam logic [ADDR_BUS:0] LEN_ONE = (ADDR_BUS+1)'(1);

  rd_state_e             state_q, state_d;
  logic [ADDR_BUS-1:0]   addr_q, addr_d;
  logic [ADDR_BUS:0]     len_q, len_d, issued_q, issued_d;
  logic                  done_q, done_d;
  logic [RD_LATENCY:0]   vld_pipe, last_pipe;
  logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
  logic                  issue, issue_last, flush, hdr_push;
  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [FW-1:0]         fifo_wdata, fifo_rdata;
  logic [CW:0]           fifo_count;
  logic [CW+1:0]         credits_used;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    flush    = 1'b0;
    hdr_push = 1'b0;

    // Every sample in flight or buffered holds a FIFO slot, so the FIFO can never overflow
    credits_used = (CW+2)'($countones(vld_pipe_q)) + (CW+2)'(fifo_count);
    issue = ((state_q == ST_READ) || (state_q == ST_HDR)) && !rd_abort && !reset &&
            (issued_q != len_q) && (credits_used < CREDITS);
    issue_last = issue && ((issued_q + LEN_ONE) == len_q);
    if (issue) begin
      addr_d   = ADDR_BUS'(wrap_add(32'(addr_q), 32'd1, RAM_SIZE));
      issued_d = issued_q + LEN_ONE;
    end

    case (state_q)
      ST_IDLE: if (rd_start) begin
        addr_d   = ADDR_BUS'(wrap_add(32'(rd_end_ptr), RAM_SIZE - 32'(rd_len), RAM_SIZE));
        len_d    = rd_len;
        issued_d = '0;
`ifdef MEM_READER_HEADER_EN
        hdr_push = 1'b1;
        state_d  = ST_HDR;
`else
        if (rd_len == '0) done_d = 1'b1;
        else              state_d = ST_READ;
`endif
      end
      // Header sits at the FIFO head, so the first pop is always the header beat
      ST_HDR:   if (fifo_pop) state_d = (len_q == '0) ? ST_DRAIN : ST_READ;
      ST_READ:  if (issued_d == len_q) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && (vld_pipe_q == '0)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase

    if (rd_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      flush   = 1'b1;
    end

    vld_pipe    = {vld_pipe_q, issue};
    last_pipe   = {last_pipe_q, issue_last};
    vld_pipe_d  = flush ? '0 : vld_pipe[RD_LATENCY-1:0];
    last_pipe_d = last_pipe[RD_LATENCY-1:0];

    fifo_push  = hdr_push || vld_pipe[RD_LATENCY];
    fifo_wdata = {last_pipe[RD_LATENCY], av_readdata};
`ifdef MEM_READER_HEADER_EN
    if (hdr_push) fifo_wdata = {rd_len == '0, DATA_W'(pulse_coord)};
`endif
  end

`ifndef MEM_READER_HEADER_EN
  logic unused_coord;
  assign unused_coord = ^pulse_coord;
`endif

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      done_q      <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

  mem_reader_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (ref_clk),
    .reset     (reset),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fifo_pop  = !fifo_empty && out_ready;
  assign av_read   = issue;
  assign av_cs     = issue;
  assign av_addr   = addr_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
  assign out_last  = !fifo_empty && fifo_rdata[DATA_W];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
endmodule

// File: tb/tb_memory_reader.sv
// Directed bench for memory_reader: RAM responder, queue model of the expected
// address/beat sequence, and a per-cycle compare process.
module tb_memory_reader;
  localparam int RAM_SIZE = 256, ADDR_BUS = 8, DATA_W = 16, RD_LATENCY = 2, FIFO_DEPTH = 4;
`ifdef MEM_READER_HEADER_EN
  localparam int HOFF = 1;
`else
  localparam int HOFF = 0;
`endif

  logic                ref_clk = 1'b0;
  logic                reset = 1'b1, rd_start = 1'b0, rd_abort = 1'b0, out_ready = 1'b0;
  logic [ADDR_BUS-1:0] rd_end_ptr = '0;
  logic [ADDR_BUS:0]   rd_len = '0;
  logic [12:0]         pulse_coord = '0;
  logic                av_cs, av_read, out_valid, out_last, busy, done;
  logic [ADDR_BUS-1:0] av_addr;
  logic [DATA_W-1:0]   av_readdata = '0, out_data;

  memory_reader #(.RAM_SIZE(RAM_SIZE), .ADDR_BUS(ADDR_BUS), .DATA_W(DATA_W),
                  .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .ref_clk(ref_clk), .reset(reset), .rd_start(rd_start), .rd_end_ptr(rd_end_ptr),
    .rd_len(rd_len), .pulse_coord(pulse_coord), .rd_abort(rd_abort), .av_cs(av_cs),
    .av_read(av_read), .av_addr(av_addr), .av_readdata(av_readdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done));

  always #5 ref_clk = ~ref_clk;

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_BUS-1:0] a);
    return {8'hC3, a ^ 8'h5A};
  endfunction

  // RAM: data for a strobe in cycle s is presented from the middle of cycle s+2
  logic [ADDR_BUS-1:0] p0 = '0, p1 = '0;
  always @(negedge ref_clk) begin
    av_readdata = ram_word(p1);
    p1 = p0;
    p0 = av_addr;
  end

  typedef struct packed { logic [DATA_W-1:0] data; logic last; } beat_t;
  beat_t               exp_beats[$];
  logic [ADDR_BUS-1:0] exp_addr[$], got_addr[$];
  logic [DATA_W-1:0]   got_data[$];
  int errors = 0, checks = 0, done_cnt = 0, beat_cnt = 0, stall_cnt = 0;
  logic  hold_pend = 1'b0;
  beat_t hold_beat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge ref_clk) begin
    beat_t b;
    if (reset) hold_pend = 1'b0;
    else begin
      if (done) done_cnt++;
      if (av_read) begin
        got_addr.push_back(av_addr);
        check("av_cs", 32'(av_cs), 32'd1);
        if (exp_addr.size() == 0) check("unexpected_av_read", 32'd1, 32'd0);
        else check("av_addr", 32'(av_addr), 32'(exp_addr.pop_front()));
      end else if (busy && exp_addr.size() != 0) stall_cnt++;
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_beat", 32'({out_data, out_last}), 32'(hold_beat));
      end
      hold_pend = out_valid && !out_ready && !rd_abort;
      hold_beat = {out_data, out_last};
      if (out_valid && out_ready) begin
        beat_cnt++;
        got_data.push_back(out_data);
        if (exp_beats.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
        else begin
          b = exp_beats.pop_front();
          check("out_data", 32'(out_data), 32'(b.data));
          check("out_last", 32'(out_last), 32'(b.last));
        end
      end
    end
  end

  task automatic start_read(input int endp, input int len, input logic [12:0] coord);
    beat_t e;
    int a;
    for (int i = 0; i < len; i++) begin
      a = (endp - len + i + 2 * RAM_SIZE) % RAM_SIZE;
      exp_addr.push_back(ADDR_BUS'(a));
      e.data = ram_word(ADDR_BUS'(a));
      e.last = (i == len - 1);
      exp_beats.push_back(e);
    end
`ifdef MEM_READER_HEADER_EN
    e.data = DATA_W'(coord);
    e.last = (len == 0);
    exp_beats.push_front(e);
`endif
    rd_end_ptr = ADDR_BUS'(endp);
    rd_len = (ADDR_BUS+1)'(len);
    pulse_coord = coord;
    rd_start = 1'b1;
    @(posedge ref_clk); #1;
    rd_start = 1'b0;
    rd_abort = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready one cycle in three
  task automatic wait_done(input string name, input int d0, input int mode, input int budget);
    int cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      out_ready = (mode == 0) || (cyc % 3 == 0);
      @(posedge ref_clk); #1;
      cyc++;
    end
    if (done_cnt == d0) check({name, "_timeout"}, 32'd0, 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge ref_clk);
    #1;
    check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_beats_left"}, 32'(exp_beats.size()), 32'd0);
    check({name, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic run_read(input string name, input int endp, input int len, input int mode,
                          input int budget);
    int d0 = done_cnt;
    out_ready = 1'b1;
    start_read(endp, len, 13'h0);
    wait_done(name, d0, mode, budget);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_av_read"}, 32'(av_read), 32'd0);
    check({name, "_av_cs"}, 32'(av_cs), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_out_last"}, 32'(out_last), 32'd0);
    check({name, "_out_data"}, 32'(out_data), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d0, b0, s0, cyc;
    repeat (3) @(posedge ref_clk);
    #1;
    check_idle_outputs("reset");
    check("reset_av_addr", 32'(av_addr), 32'd0);
    reset = 1'b0;
    @(posedge ref_clk); #1;

    // basic window, full rate: no credit stalls expected
    got_addr.delete(); got_data.delete(); s0 = stall_cnt;
    run_read("basic", 10, 4, 0, 100);
    check("basic_naddr", 32'(got_addr.size()), 32'd4);
    check("basic_addr0", 32'(got_addr[0]), 32'd6);
    check("basic_addr1", 32'(got_addr[1]), 32'd7);
    check("basic_addr2", 32'(got_addr[2]), 32'd8);
    check("basic_addr3", 32'(got_addr[3]), 32'd9);
    check("basic_data0", 32'(got_data[HOFF]), 32'h0000C35C);
    check("basic_data3", 32'(got_data[HOFF+3]), 32'h0000C353);
    check("basic_no_stall", 32'(stall_cnt - s0), 32'd0);

    // window crossing the RAM end
    got_addr.delete(); got_data.delete();
    run_read("wrap", 2, 5, 0, 100);
    check("wrap_naddr", 32'(got_addr.size()), 32'd5);
    check("wrap_addr0", 32'(got_addr[0]), 32'd253);
    check("wrap_addr2", 32'(got_addr[2]), 32'd255);
    check("wrap_addr3", 32'(got_addr[3]), 32'd0);
    check("wrap_addr4", 32'(got_addr[4]), 32'd1);
    check("wrap_data3", 32'(got_data[HOFF+3]), 32'h0000C35A);

    // whole RAM with a throttled sink
    b0 = beat_cnt; s0 = stall_cnt; got_addr.delete();
    run_read("full", 77, 256, 1, 2000);
    check("full_beats", 32'(beat_cnt - b0), 32'(256 + HOFF));
    check("full_addr0", 32'(got_addr[0]), 32'd77);
    check("full_stalled", 32'(stall_cnt - s0 > 0), 32'd1);

    // abort after three beats
    d0 = done_cnt; b0 = beat_cnt; out_ready = 1'b1;
    start_read(100, 20, 13'h0);
    cyc = 0;
    while (beat_cnt - b0 < 3 + HOFF && cyc < 60) begin
      @(posedge ref_clk); #1;
      cyc++;
    end
    if (beat_cnt - b0 < 3 + HOFF) check("abort_wait_timeout", 32'd0, 32'd1);
    rd_abort = 1'b1; out_ready = 1'b0;
    exp_beats.delete(); exp_addr.delete();
    @(posedge ref_clk); #1;
    rd_abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_done", 32'(done), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_beats", 32'(beat_cnt - b0), 32'(3 + HOFF));
    out_ready = 1'b1;
    repeat (6) @(posedge ref_clk);
    #1;
    check("abort_done_once", 32'(done_cnt - d0), 32'd1);
    run_read("after_abort", 30, 3, 0, 100);

    // empty window
    d0 = done_cnt; out_ready = 1'b1;
    start_read(5, 0, 13'h0);
`ifndef MEM_READER_HEADER_EN
    check("len0_done", 32'(done), 32'd1);
`endif
    wait_done("len0", d0, 0, 50);

    // rd_start while busy is ignored
    d0 = done_cnt; out_ready = 1'b1;
    start_read(40, 6, 13'h0);
    @(posedge ref_clk); #1;
    rd_end_ptr = 8'd200; rd_len = 9'd9; rd_start = 1'b1;
    @(posedge ref_clk); #1;
    rd_start = 1'b0;
    wait_done("busy_start", d0, 0, 100);

    // start together with abort in IDLE is a normal start
    d0 = done_cnt; out_ready = 1'b1; rd_abort = 1'b1;
    start_read(50, 3, 13'h0);
    wait_done("start_abort", d0, 0, 100);

    // reset in the middle of a read with a stalled sink
    out_ready = 1'b0;
    start_read(150, 50, 13'h0);
    repeat (6) @(posedge ref_clk);
    #1;
    reset = 1'b1;
    exp_beats.delete(); exp_addr.delete();
    repeat (2) @(posedge ref_clk);
    #1;
    reset = 1'b0;
    check_idle_outputs("midreset");
    run_read("after_reset", 60, 4, 0, 100);

`ifdef MEM_READER_HEADER_EN
    got_data.delete(); d0 = done_cnt; out_ready = 1'b1;
    start_read(20, 2, 13'h1ABC);
    wait_done("header", d0, 0, 100);
    check("header_word", 32'(got_data[0]), 32'h00001ABC);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
